// File: rtl/writeback_stage.sv
// Final RISC-V pipeline stage: 2-entry skid buffer, load extension, writeback source select
// and register-file write port. Define WB_INSTRET_EN to add the 64-bit instret counter/port.
module writeback_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     IR,
  input  logic [XLEN-1:0] RD,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] PC,
  input  logic [4:0]      AM,
  input  logic            v_in,
  input  logic            stall,
  output logic            r_out,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            v_out
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // Only the decode fields of IR are kept; the rest of the word is irrelevant at writeback.
  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] pc;
    logic [4:0]      am;
  } entry_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] data;
  } wb_src_t;

  function automatic wb_src_t wb_source(input entry_t e);
    wb_src_t s;
    s.write = 1'b0;
    s.data  = '0;
    case (e.opcode)
      OPC_LOAD: begin
        s.write = 1'b1;
        case (e.funct3)
          3'b000:  s.data = {{(XLEN-8){e.rd[7]}}, e.rd[7:0]};
          3'b001:  s.data = {{(XLEN-16){e.rd[15]}}, e.rd[15:0]};
          3'b010:  s.data = e.rd;
          3'b100:  s.data = {{(XLEN-8){1'b0}}, e.rd[7:0]};
          3'b101:  s.data = {{(XLEN-16){1'b0}}, e.rd[15:0]};
          default: s.write = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        s.write = 1'b1;
        s.data  = e.pc + XLEN'(4);
      end
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
        s.write = 1'b1;
        s.data  = e.a;
      end
      default: s.write = 1'b0;
    endcase
    return s;
  endfunction

  entry_t     buf0, buf1;   // buf0 is always the head
  entry_t     in_entry;
  wb_src_t    head_src;
  logic [1:0] occ, occ_next, occ_after_pop;
  logic       accept, retire;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^{IR[31:15], IR[11:7]};

  assign in_entry = '{opcode: IR[6:0], funct3: IR[14:12], rd: RD, a: A, pc: PC, am: AM};

  // Retire looks at pre-edge occupancy, so an entry accepted into an empty buffer waits a cycle.
  assign accept        = v_in & r_out;
  assign retire        = ~stall & (occ != 2'd0);
  assign occ_after_pop = occ - {1'b0, retire};
  assign occ_next      = occ_after_pop + {1'b0, accept};
  assign head_src      = wb_source(buf0);

  // NOTE: non-blocking assignments for every registered signal so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ     <= 2'd0;
      r_out   <= 1'b1;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      v_out   <= 1'b0;
    end else begin
      occ   <= occ_next;
      // Dropping ready at one entry under stall leaves room for the accept already in flight.
      r_out <= (occ_next == 2'd0) | ((occ_next == 2'd1) & ~stall);
      if (retire) begin
        v_out   <= 1'b1;
        wb_en   <= head_src.write & (buf0.am != 5'd0);
        wb_addr <= buf0.am;
        wb_data <= head_src.data;
      end else begin
        v_out <= 1'b0;
        wb_en <= 1'b0;
      end
    end
  end

  // NOTE: the buffer storage has no reset; occupancy alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (accept && (occ_after_pop == 2'd0)) begin
      buf0 <= in_entry;
    end else if (retire) begin
      buf0 <= buf1;
    end
    if (accept && (occ_after_pop == 2'd1)) begin
      buf1 <= in_entry;
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow_accept: assert property (@(posedge clk) disable iff (rst)
    !(v_in && r_out && (occ == 2'd2)));

  a_occ_within_depth: assert property (@(posedge clk) disable iff (rst)
    int'(occ) <= DEPTH);
`endif

endmodule
